luma16x16_mode_decision: RTL and testbench

Row-streamed SAD mode selector for Intra 16x16 luma. It sits directly downstream of the luma 16x16 predictor (V/H/DC prediction arrays). For one macroblock it accepts the original pixels and the three predictions one 16-pixel row per handshake, and accumulates a sum of absolute differences per mode. After the 16th row it reports the cheapest available mode and its cost.

---
 rtl/luma16x16_mode_decision.sv | 128 ++++++++++++
 tb/tb_luma16x16_mode_decision.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/luma16x16_mode_decision.sv
// Intra 16x16 luma mode selector: accumulates per-row SADs for the V, H and DC
// predictions over one macroblock and reports the cheapest available mode.
module luma16x16_mode_decision (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         top_avail,
  input  logic         left_avail,
  input  logic         row_valid,
  output logic         row_ready,
  input  logic [127:0] orig_row,
  input  logic [127:0] vpred_row,
  input  logic [127:0] hpred_row,
  input  logic [127:0] dcpred_row,
  output logic         busy,
  output logic         done,
  output logic [1:0]   best_mode,
  output logic [15:0]  best_sad,
  output logic [15:0]  sad_v,
  output logic [15:0]  sad_h,
  output logic [15:0]  sad_dc
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] DECIDE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]  state;
  logic [3:0]  row_cnt;
  logic [15:0] acc_v;
  logic [15:0] acc_h;
  logic [15:0] acc_dc;
  logic        top_lat;
  logic        left_lat;
  logic        row_fire;
  logic [11:0] row_sad_v;
  logic [11:0] row_sad_h;
  logic [11:0] row_sad_dc;
  logic [1:0]  sel_mode;
  logic [15:0] sel_sad;

  function automatic logic [11:0] row_sad(input logic [127:0] a, input logic [127:0] b);
    logic [11:0] sum;
    logic [7:0]  pa;
    logic [7:0]  pb;
    sum = '0;
    for (int k = 0; k < 16; k++) begin
      pa = a[8*k +: 8];
      pb = b[8*k +: 8];
      sum = sum + 12'((pa > pb) ? (pa - pb) : (pb - pa));
    end
    return sum;
  endfunction

  assign row_fire   = (state == ACCUM) && row_valid;
  assign row_sad_v  = row_sad(orig_row, vpred_row);
  assign row_sad_h  = row_sad(orig_row, hpred_row);
  assign row_sad_dc = row_sad(orig_row, dcpred_row);

  assign row_ready = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // DC is the fallback; H then V override on <= so ties resolve to the lower mode number
  always_comb begin
    sel_mode = 2'd2;
    sel_sad  = acc_dc;
    if (left_lat && (acc_h <= sel_sad)) begin
      sel_mode = 2'd1;
      sel_sad  = acc_h;
    end
    if (top_lat && (acc_v <= sel_sad)) begin
      sel_mode = 2'd0;
      sel_sad  = acc_v;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row_cnt   <= '0;
      acc_v     <= '0;
      acc_h     <= '0;
      acc_dc    <= '0;
      top_lat   <= 1'b0;
      left_lat  <= 1'b0;
      best_mode <= 2'd2;
      best_sad  <= '0;
      sad_v     <= '0;
      sad_h     <= '0;
      sad_dc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_cnt  <= '0;
            acc_v    <= '0;
            acc_h    <= '0;
            acc_dc   <= '0;
            top_lat  <= top_avail;
            left_lat <= left_avail;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (row_fire) begin
            acc_v   <= acc_v  + 16'(row_sad_v);
            acc_h   <= acc_h  + 16'(row_sad_h);
            acc_dc  <= acc_dc + 16'(row_sad_dc);
            row_cnt <= row_cnt + 4'd1;
            if (row_cnt == 4'd15) state <= DECIDE;
          end
        end
        DECIDE: begin
          best_mode <= sel_mode;
          best_sad  <= sel_sad;
          sad_v     <= acc_v;
          sad_h     <= acc_h;
          sad_dc    <= acc_dc;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_luma16x16_mode_decision.sv
// Directed bench for luma16x16_mode_decision with hand-computed SAD expectations.
module tb_luma16x16_mode_decision;

  logic         clk;
  logic         reset;
  logic         start;
  logic         top_avail;
  logic         left_avail;
  logic         row_valid;
  logic         row_ready;
  logic [127:0] orig_row;
  logic [127:0] vpred_row;
  logic [127:0] hpred_row;
  logic [127:0] dcpred_row;
  logic         busy;
  logic         done;
  logic [1:0]   best_mode;
  logic [15:0]  best_sad;
  logic [15:0]  sad_v;
  logic [15:0]  sad_h;
  logic [15:0]  sad_dc;

  int n_checks = 0;
  int n_fail   = 0;

  luma16x16_mode_decision dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .top_avail  (top_avail),
    .left_avail (left_avail),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .orig_row   (orig_row),
    .vpred_row  (vpred_row),
    .hpred_row  (hpred_row),
    .dcpred_row (dcpred_row),
    .busy       (busy),
    .done       (done),
    .best_mode  (best_mode),
    .best_sad   (best_sad),
    .sad_v      (sad_v),
    .sad_h      (sad_h),
    .sad_dc     (sad_dc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_mb(input logic top, input logic left);
    start      = 1'b1;
    top_avail  = top;
    left_avail = left;
    step();
    start = 1'b0;
    check("start_row_ready", int'(row_ready), 1);
    check("start_busy", int'(busy), 1);
  endtask

  task automatic send_row(input logic [127:0] o, input logic [127:0] v,
                          input logic [127:0] h, input logic [127:0] d);
    row_valid  = 1'b1;
    orig_row   = o;
    vpred_row  = v;
    hpred_row  = h;
    dcpred_row = d;
    step();
    row_valid = 1'b0;
    orig_row  = rep(8'hff);
    vpred_row = '0;
    hpred_row = '0;
    dcpred_row = '0;
  endtask

  task automatic send_rows(input int n, input logic [127:0] o, input logic [127:0] v,
                           input logic [127:0] h, input logic [127:0] d);
    for (int r = 0; r < n; r++) send_row(o, v, h, d);
  endtask

  // Leaves the bench inside the done cycle, giving up after a fixed budget
  task automatic wait_done(input string tag);
    for (int c = 0; c < 6; c++) begin
      if (done) break;
      step();
    end
    check(tag, int'(done), 1);
  endtask

  task automatic check_results(input string tag, input int v, input int h, input int d,
                               input int mode, input int bsad);
    check({tag, "_sad_v"}, int'(sad_v), v);
    check({tag, "_sad_h"}, int'(sad_h), h);
    check({tag, "_sad_dc"}, int'(sad_dc), d);
    check({tag, "_best_mode"}, int'(best_mode), mode);
    check({tag, "_best_sad"}, int'(best_sad), bsad);
  endtask

  initial begin
    logic [127:0] col_ramp;

    reset = 1'b0;
    start = 1'b0;
    top_avail = 1'b0;
    left_avail = 1'b0;
    row_valid = 1'b0;
    orig_row = '0;
    vpred_row = '0;
    hpred_row = '0;
    dcpred_row = '0;

    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_row_ready", int'(row_ready), 0);
    check("rst_done", int'(done), 0);
    check_results("rst", 0, 0, 0, 2, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    $display("[TB] tie case");
    start_mb(1'b1, 1'b1);
    send_rows(16, rep(8'd100), rep(8'd100), rep(8'd90), rep(8'd100));
    check("tie_done_decide", int'(done), 0);
    check("tie_busy_decide", int'(busy), 1);
    check("tie_row_ready_decide", int'(row_ready), 0);
    step();
    check("tie_done_pulse", int'(done), 1);
    check_results("tie", 0, 2560, 0, 0, 0);
    step();
    check("tie_done_fall", int'(done), 0);
    check("tie_busy_fall", int'(busy), 0);

    $display("[TB] availability");
    start_mb(1'b0, 1'b1);
    send_rows(16, rep(8'd50), rep(8'd50), rep(8'd50), rep(8'd60));
    wait_done("avail_done");
    check_results("avail", 0, 0, 2560, 1, 0);
    step();

    $display("[TB] max range");
    start_mb(1'b1, 1'b1);
    send_rows(16, rep(8'd255), '0, '0, '0);
    wait_done("max_done");
    check_results("max", 65280, 65280, 65280, 0, 65280);
    step();

    $display("[TB] row gaps");
    start_mb(1'b1, 1'b1);
    for (int r = 0; r < 16; r++) begin
      int gaps;
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        orig_row = rep(8'hff);
        step();
      end
      send_row(rep(8'(r)), '0, rep(8'd15), rep(8'd7));
    end
    check("gap_busy_decide", int'(busy), 1);
    wait_done("gap_done");
    check_results("gap", 1920, 1920, 1024, 2, 1024);
    step();

    $display("[TB] reset mid-op");
    start_mb(1'b1, 1'b1);
    send_rows(8, rep(8'd10), rep(8'd20), rep(8'd30), rep(8'd40));
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_row_ready", int'(row_ready), 0);
    check("midrst_done", int'(done), 0);
    check_results("midrst", 0, 0, 0, 2, 0);
    step();
    check("midrst_held_done", int'(done), 0);
    reset = 1'b1;
    step();
    check("midrst_idle_busy", int'(busy), 0);

    for (int k = 0; k < 16; k++) col_ramp[8*k +: 8] = 8'(16 * k);
    start_mb(1'b1, 1'b1);
    send_rows(16, col_ramp, '0, rep(8'd255), rep(8'd128));
    wait_done("ramp_done");
    check_results("ramp", 30720, 34560, 16384, 2, 16384);
    step();

    $display("[TB] start ignored");
    start_mb(1'b1, 1'b1);
    send_rows(5, rep(8'd20), rep(8'd30), rep(8'd20), rep(8'd25));
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_still_accum", int'(row_ready), 1);
    send_rows(11, rep(8'd20), rep(8'd30), rep(8'd20), rep(8'd25));
    check("ign_done_decide", int'(done), 0);
    step();
    check("ign_done_pulse", int'(done), 1);
    check_results("ign", 2560, 0, 1280, 1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_busy_after_done", int'(busy), 0);
    check("ign_done_after", int'(done), 0);
    step();
    check("ign_no_extra_mb", int'(busy), 0);
    check_results("ign_held", 2560, 0, 1280, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
